// File: rtl/fp_wire.sv
// fp_wire: shared FP operation encoding, issue records and issue-stage state enumeration.
package fp_wire;
  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmsub;
    logic fnmadd;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fcmp;
    logic fmax;
    logic fcvt_f2i;
    logic fcvt_i2f;
    logic fmv_f2i;
    logic fmv_i2f;
    logic fclass;
    logic fpuf;
  } fp_operation_type;
  localparam fp_operation_type OP_NONE     = '0;
  localparam fp_operation_type OP_FMADD    = '{fmadd: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FADD     = '{fadd: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FSUB     = '{fsub: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FMUL     = '{fmul: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FDIV     = '{fdiv: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FSQRT    = '{fsqrt: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FSGNJ    = '{fsgnj: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FCMP     = '{fcmp: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FMAX     = '{fmax: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FCVT_F2I = '{fcvt_f2i: 1'b1, fpuf: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FMV_F2I  = '{fmv_f2i: 1'b1, default: 1'b0};
  localparam fp_operation_type OP_FCLASS   = '{fclass: 1'b1, default: 1'b0};
  localparam logic [2:0] RM_DYN = 3'd7;
  typedef struct packed {
    fp_operation_type op;
    logic [2:0]       rm;
    logic             fwren;
    logic             wren;
    logic [4:0]       waddr;
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
  } fp_issue_in_type;
  typedef struct packed {
    logic             exe_enable;
    fp_operation_type op;
    logic [2:0]       rm;
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic             fwb_wren;
    logic             iwb_wren;
    logic [4:0]       waddr;
    logic [31:0]      wdata;
    logic             csr_fpu;
    logic [4:0]       fflags;
    logic             busy;
    logic             timeout_err;
  } fp_issue_out_type;
  typedef enum logic [1:0] {IDLE, WAIT, WB} fp_issue_state_type;
endpackage

// File: rtl/fpu_issue.sv
// fpu_issue: hands one FP op at a time to the execute unit, waits with a timeout,
// then writes the result back to the FP or integer file and updates fflags.
module fpu_issue
  import fp_wire::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  fp_operation_type issue_op,
  input  logic [2:0]       issue_rm,
  input  logic             issue_fwren,
  input  logic             issue_wren,
  input  logic [4:0]       issue_waddr,
  input  logic [31:0]      issue_data1,
  input  logic [31:0]      issue_data2,
  input  logic [31:0]      issue_data3,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic             exe_enable,
  output fp_operation_type exe_op,
  output logic [2:0]       exe_rm,
  output logic [31:0]      exe_data1,
  output logic [31:0]      exe_data2,
  output logic [31:0]      exe_data3,
  input  logic             exe_ready,
  input  logic [31:0]      exe_result,
  input  logic [4:0]       exe_flags,
  output logic             fwb_wren,
  output logic [4:0]       fwb_waddr,
  output logic [31:0]      fwb_wdata,
  output logic             iwb_wren,
  output logic [4:0]       iwb_waddr,
  output logic [31:0]      iwb_wdata,
  output logic             csr_fpu,
  output logic [4:0]       csr_fflags,
  output logic             busy,
  output logic             timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  fp_issue_state_type state, state_n;
  fp_issue_in_type    lat;
  logic [CW-1:0]      cnt;
  logic [31:0]        res;
  logic [4:0]         flg;
  logic               en, accept, done, expire;
  // WB also accepts, so a new op can start while the previous result is written
  always_comb begin
    accept  = reset && issue_valid && !flush && state != WAIT;
    done    = state == WAIT && !flush && exe_ready;
    expire  = state == WAIT && !flush && !exe_ready && cnt == CW'(TIMEOUT);
    state_n = accept ? WAIT
            : (state == WB || (state == WAIT && (flush || expire))) ? IDLE
            : done ? WB : state;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
      res   <= '0;
      flg   <= '0;
      en    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
      en    <= accept;
      if (accept)
        lat <= '{op: issue_op, rm: (issue_rm == RM_DYN) ? frm : issue_rm,
                 fwren: issue_fwren, wren: issue_wren, waddr: issue_waddr,
                 data1: issue_data1, data2: issue_data2, data3: issue_data3};
      if (done) begin
        res <= exe_result;
        flg <= exe_flags;
      end
    end
  end
  assign issue_ready = reset && state != WAIT;
  assign exe_enable  = en;
  assign exe_op      = lat.op;
  assign exe_rm      = lat.rm;
  assign exe_data1   = lat.data1;
  assign exe_data2   = lat.data2;
  assign exe_data3   = lat.data3;
  assign fwb_wren    = reset && state == WB && lat.fwren;
  assign fwb_waddr   = lat.waddr;
  assign fwb_wdata   = res;
  // integer x0 is hardwired to zero, f0 is a real register
  assign iwb_wren    = reset && state == WB && lat.wren && lat.waddr != 5'd0;
  assign iwb_waddr   = lat.waddr;
  assign iwb_wdata   = res;
  assign csr_fpu     = reset && state == WB && lat.op.fpuf;
  assign csr_fflags  = flg;
  assign busy        = reset && state != IDLE;
  assign timeout_err = reset && expire;
endmodule
